contador_ctrl: RTL

CONTADOR_CTRL -- requirements
Module: contador_ctrl

---
 rtl/contador_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/contador_ctrl.sv
// Command sequencer for a 4-bit loadable counter: preload, count a number of wraps, report Q.
// Optional idle-cycle watchdog in LOAD/RUN is built only when CTRL_TIMEOUT_EN is defined.
module contador_ctrl #(
    parameter int TO_MAX = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [3:0] cmd_D,
    input  logic [3:0] cmd_wraps,
    input  logic       abort,
    output logic       enable,
    output logic [1:0] mode,
    output logic [3:0] D,
    input  logic       load,
    input  logic       rco,
    input  logic [3:0] Q,
    output logic       busy,
    output logic       done,
    output logic [3:0] done_Q,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t     state;
    logic [1:0] run_mode;
    logic [3:0] wraps;
    logic [4:0] wrap_cnt;
    logic [4:0] wrap_last;
    logic       timeout_hit;

    if (TO_MAX < 1 || TO_MAX > 255) begin : g_bad_to_max
        $error("contador_ctrl: TO_MAX must be in 1..255");
    end

    // A wraps field of zero means sixteen pulses, hence the 5-bit target.
    assign wrap_last = {(wraps == 4'd0), wraps} - 5'd1;

`ifdef CTRL_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TO_MAX - 1);

    logic [7:0] to_cnt;

    assign timeout_hit = (to_cnt == TO_LIMIT) && !abort &&
                         ((state == LOAD && !load) || (state == RUN && !rco));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= 8'd0;
            err    <= 1'b0;
        end else begin
            err <= timeout_hit;
            if (state == IDLE || state == DONE)
                to_cnt <= 8'd0;
            else if ((state == LOAD && load) || (state == RUN && rco))
                to_cnt <= 8'd0;
            else
                to_cnt <= to_cnt + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            enable    <= 1'b0;
            mode      <= 2'b00;
            D         <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_Q    <= 4'd0;
            run_mode  <= 2'b00;
            wraps     <= 4'd0;
            wrap_cnt  <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        run_mode  <= cmd_mode;
                        wraps     <= cmd_wraps;
                        D         <= cmd_D;
                        mode      <= 2'b11;
                        enable    <= 1'b1;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort || timeout_hit) begin
                        enable    <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (load) begin
                        if (run_mode == 2'b11) begin
                            enable <= 1'b0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            mode     <= run_mode;
                            wrap_cnt <= 5'd0;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Abort outranks a coinciding final rco.
                    if (abort || timeout_hit) begin
                        enable    <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (rco) begin
                        wrap_cnt <= wrap_cnt + 5'd1;
                        if (wrap_cnt == wrap_last) begin
                            enable <= 1'b0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_Q    <= Q;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
